// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port data memory between the pipeline MEM-stage
//            port (M) and a loader/debug port (D). Serialises accesses, models
//            a fixed read latency and stalls the pipeline until its access is
//            acknowledged.
// Options  : DMEM_ARB_STARVE_GUARD_EN - when defined, D is forced through
//            after MAX_WAIT consecutive M grants made while D was waiting.
//            When undefined, M has strict priority.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int RD_LAT   = 2,  // read latency in BUSY cycles, >= 1
    parameter int MAX_WAIT = 4   // M grants tolerated while D waits (guard build)
) (
    input  logic        CLK,
    input  logic        RST,
    // pipeline port
    input  logic        ReqM,
    input  logic        WEM,
    input  logic [31:0] AM,
    input  logic [31:0] WDM,
    output logic        AckM,
    output logic [31:0] RDM,
    output logic        StallM,
    // loader / debug port
    input  logic        ReqD,
    input  logic        WED,
    input  logic [31:0] AD,
    input  logic [31:0] WDD,
    output logic        AckD,
    output logic [31:0] RDD,
    // data memory side
    output logic [31:0] MemA,
    output logic [31:0] MemWD,
    output logic        MemWE,
    input  logic [31:0] MemRD
);

    // Countdown width; a one-bit counter is kept even when RD_LAT is 1 so the
    // datapath shape does not change between builds.
    localparam int c_CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(RD_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic c_OWNER_M = 1'b0;
    localparam logic c_OWNER_D = 1'b1;

    typedef enum logic [0:0] {
        c_ST_IDLE = 1'b0,
        c_ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;      // remaining BUSY cycles before the ack cycle
    logic                r_owner;    // port that owns the current access
    logic                r_first;    // high during the first BUSY cycle only
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;

    logic                w_grantM;
    logic                w_grantD;
    logic                w_grantAny;
    logic                w_winWe;
    logic [31:0]         w_winAddr;
    logic [31:0]         w_winWdata;
    logic                w_ackCycle;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int c_STARVE_W = $clog2(MAX_WAIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(MAX_WAIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);

    logic [c_STARVE_W-1:0] r_starve;  // consecutive M grants made while D waited
    logic                  w_forceD;

    assign w_forceD = ReqD && (r_starve == c_STARVE_MAX);

    // Arbitration: a starved D overrides M, otherwise M first, then D.
    always_comb begin
        w_grantM = 1'b0;
        w_grantD = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (w_forceD) begin
                w_grantD = 1'b1;
            end else if (ReqM) begin
                w_grantM = 1'b1;
            end else if (ReqD) begin
                w_grantD = 1'b1;
            end
        end
    end

    // Starvation counter: counts M grants that passed over a waiting D and
    // restarts whenever D is served or is not waiting at a grant decision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve <= '0;
        end else if (w_grantAny) begin
            if (w_grantD || !ReqD) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + c_STARVE_ONE;
            end
        end
    end
`else
    // MAX_WAIT only matters for the guarded build.
    logic w_unusedMaxWait;
    assign w_unusedMaxWait = (MAX_WAIT > 0);

    // Arbitration: strict M priority, D only when M is not requesting.
    always_comb begin
        w_grantM = 1'b0;
        w_grantD = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (ReqM) begin
                w_grantM = 1'b1;
            end else if (ReqD) begin
                w_grantD = 1'b1;
            end
        end
    end
`endif

    assign w_grantAny = w_grantM | w_grantD;

    // Winner's request fields, captured only at the grant.
    assign w_winWe    = w_grantD ? WED : WEM;
    assign w_winAddr  = w_grantD ? AD  : AM;
    assign w_winWdata = w_grantD ? WDD : WDM;

    // Access sequencer: latch the winner in IDLE, count down in BUSY, and
    // return to IDLE after the ack cycle so a bubble always follows an ack.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_owner <= c_OWNER_M;
            r_first <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_first <= 1'b0;
                    if (w_grantAny) begin
                        r_state <= c_ST_BUSY;
                        r_owner <= w_grantD ? c_OWNER_D : c_OWNER_M;
                        r_we    <= w_winWe;
                        r_addr  <= w_winAddr;
                        r_wdata <= w_winWdata;
                        r_first <= 1'b1;
                        r_cnt   <= w_winWe ? '0 : c_RD_LOAD;
                    end
                end
                c_ST_BUSY: begin
                    r_first <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Ack cycle; masked while reset is asserted so a dropped access never
    // completes.
    assign w_ackCycle = (r_state == c_ST_BUSY) && (r_cnt == '0) && !RST;

    // Completion, read-data pass-through and pipeline stall.
    assign AckM   = w_ackCycle && (r_owner == c_OWNER_M);
    assign AckD   = w_ackCycle && (r_owner == c_OWNER_D);
    assign RDM    = AckM ? MemRD : '0;
    assign RDD    = AckD ? MemRD : '0;
    assign StallM = ReqM && !AckM;

    // Memory side: address/data come straight from the latched request; the
    // write strobe fires once, in the first BUSY cycle of a write.
    assign MemA  = r_addr;
    assign MemWD = r_wdata;
    assign MemWE = (r_state == c_ST_BUSY) && r_first && r_we && !RST;

endmodule
`default_nettype wire
